// File: rtl/ser_word_rx.sv
// ser_word_rx: serial-to-parallel receiver. Assembles N serial bits (MSB- or
// LSB-first, order latched at bit 0) into a word and presents it through a
// single-entry valid/ready holding register with overrun detection.
module ser_word_rx #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_in,
  input  logic          s_valid,
  input  logic          lsb_first,
  input  logic          frame_sync,
  output logic [N-1:0]  p_out,
  output logic          p_valid,
  input  logic          p_ready,
  output logic          overrun,
  output logic [CW-1:0] bit_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  asm_q, asm_d, base, shifted;
  logic [CW-1:0] cnt_d;
  logic          order_q, order_d, eff_lsb;
  logic          last_bit, complete, load, overrun_d;

  // Shift path: a frame_sync edge starts from an empty register at bit 0,
  // so the order is taken live from lsb_first in that case too.
  always_comb begin
    last_bit = (bit_cnt == CW'(N - 1));
    eff_lsb  = (bit_cnt == '0 || frame_sync) ? lsb_first : order_q;
    base     = frame_sync ? '0 : asm_q;
    shifted  = eff_lsb ? {s_in, base[N-1:1]} : {base[N-2:0], s_in};
    complete = s_valid && !frame_sync && last_bit;
  end

  // Next assembly register, bit counter and latched order.
  always_comb begin
    asm_d   = asm_q;
    cnt_d   = bit_cnt;
    order_d = order_q;
    if (frame_sync) begin
      asm_d = '0;
      cnt_d = '0;
      if (s_valid) begin
        asm_d   = shifted;
        cnt_d   = CW'(1);
        order_d = lsb_first;
      end
    end else if (s_valid) begin
      asm_d = shifted;
      if (bit_cnt == '0) order_d = lsb_first;
      cnt_d = last_bit ? '0 : bit_cnt + CW'(1);
    end
  end

  // Output FSM: holding register occupancy, reload and overrun decisions.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (p_ready) load = 1'b1;
          else         overrun_d = 1'b1;
        end else if (p_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      asm_q   <= '0;
      bit_cnt <= '0;
      order_q <= 1'b0;
      p_out   <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      bit_cnt <= cnt_d;
      order_q <= order_d;
      overrun <= overrun_d;
      if (load) p_out <= shifted;
    end
  end

  assign p_valid = (state_q == FULL);

endmodule

// File: doc/ser_word_rx.md
Name: ser_word_rx

Overview:
- Serial-to-parallel receiver: the receiving end of the serial stream our universal shift register emits on its serial output.
- Collects N bits, MSB-first or LSB-first, into one word and presents it on a parallel valid/ready output.
- Single-entry output holding register, so the sender can start the next word while the consumer stalls.
- Overrun detection for words that complete while the holding register is still occupied.

Parameters:
- N, 8, word width in bits (N >= 2).
- CW, $clog2(N), width of bit counter (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- s_in  input  1  serial data bit.
- s_valid  input  1  s_in carries a valid bit this cycle; gaps allowed.
- lsb_first  input  1  bit order: 0 = MSB-first, 1 = LSB-first. Sampled only on bit 0 of each word.
- frame_sync  input  1  synchronous abort of the partial word; realigns to word boundary.
- p_out  output  N  received word (registered).
- p_valid  output  1  p_out holds an unconsumed word.
- p_ready  input  1  consumer accepts p_out when p_valid && p_ready.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- bit_cnt  output  CW  bits collected in the current partial word (0..N-1).

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - p_out=0, p_valid=0, overrun=0, bit_cnt=0.
  - Assembly shift register=0; latched order=MSB-first.
  - Reset asserted mid-word discards the partial word and any held word.
- Bit capture: on each rising edge with s_valid=1:
  - MSB-first: asm <= {asm[N-2:0], s_in}, so the first bit ends at bit N-1.
  - LSB-first: asm <= {s_in, asm[N-1:1]}, so the first bit ends at bit 0.
  - Order is latched when bit_cnt==0 and held for the rest of the word; changing lsb_first mid-word has no effect until the next word.
  - bit_cnt increments; it wraps N-1 -> 0 on the completing bit.
- Word completion: the edge that captures bit N-1 forms the word from asm plus the current s_in.
  - If the holding register is empty, or is being consumed that same edge (p_valid && p_ready): p_out <= word, p_valid <= 1 after that edge. Latency is 1 cycle from the last bit's capture edge to p_valid high.
  - Else the word is dropped, p_out and p_valid are unchanged, and overrun=1 for exactly one cycle.
- Output FSM, 2 states:
  - EMPTY -> FULL on word completion.
  - FULL -> EMPTY on p_ready with no completion.
  - FULL -> FULL on completion with simultaneous p_ready (reload, no overrun), or on completion without p_ready (drop plus overrun).
- p_out is stable while p_valid=1 and not consumed; p_ready is ignored while p_valid=0.
- frame_sync=1 on an edge:
  - Clears bit_cnt and asm; the held word is unaffected.
  - If s_valid is also 1 that edge, s_in is captured as bit 0 of a fresh word and lsb_first is latched (bit_cnt becomes 1).
- frame_sync on the same edge that would complete a word: frame_sync wins. No word is produced, and the bit is taken as bit 0 of the new word.
- Idle s_valid=0 cycles hold all state.

Test Plan:
- MSB-first: reset, lsb_first=0, p_ready=1, s_in sequence 1,0,1,0,1,0,1,1 on consecutive cycles -> p_valid=1 one cycle after the 8th bit, p_out=8'hAB, bit_cnt back to 0, overrun never asserted.
- LSB-first with gaps: lsb_first=1, bits 1,1,0,1,0,1,0,1 with s_valid low on every other cycle; lsb_first toggled to 0 after bit 3 -> p_out=8'hAB, proving order is latched at bit 0.
- Backpressure and overrun:
  - p_ready=0; send 8'hAB then 8'hCD (MSB-first) -> p_out stays 8'hAB, p_valid=1, overrun pulses exactly once on the CD completion edge.
  - Then p_ready=1 for one cycle -> p_valid=0.
- Simultaneous consume and complete: hold 8'hAB, assert p_ready exactly on the edge capturing the last bit of 8'h3C -> p_out=8'h3C, p_valid stays 1, no overrun.
- Resync:
  - Send 3 bits 1,1,1, pulse frame_sync with s_valid=0 -> bit_cnt=0.
  - Then send 8'hCD -> p_out=8'hCD.
  - Repeat with frame_sync coincident with the first CD bit -> same result.
- Async reset: assert reset=0 between clock edges with bit_cnt=5 and p_valid=1 -> p_out=0, p_valid=0, bit_cnt=0 immediately. After release, 8'hAB is received correctly.
